// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall sequencer: merges ID/EX/MEM stall requests, runs the EX
// multi-cycle counter, drives flush and keeps a saturating stall-cycle count.
//   state   | meaning
//   IDLE    | no multi-cycle EX op in flight
//   EX_BUSY | multi-cycle op running, cnt = remaining stalled EX cycles
module pipe_stall_ctrl #(
  parameter int CNT_W  = 4,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              ex_mc_req,
  input  logic [CNT_W-1:0]  ex_mc_len,
  input  logic              mem_req,
  input  logic              mem_ack,
  input  logic              flush_req,
  output logic [5:0]        stall,
  output logic              flush,
  output logic              ex_mc_en,
  output logic              ex_mc_done,
  output logic              busy,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic {IDLE, EX_BUSY} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PERF_W-1:0]   stall_cycles_q, stall_cycles_d;
  logic                mem_stall;
  logic                ex_stall;
  logic                done_raw;
  logic [5:0]          stall_raw;

  assign mem_stall = mem_req & ~mem_ack;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ex_stall = 1'b0;
    done_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_mc_req) begin
          if (ex_mc_len <= CNT_W'(1)) begin
            done_raw = 1'b1;
          end else begin
            ex_stall = 1'b1;
            cnt_d    = ex_mc_len - CNT_W'(2);
            state_d  = EX_BUSY;
          end
        end
      end
      EX_BUSY: begin
        if (!ex_mc_req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          ex_stall = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
        end else begin
          done_raw = 1'b1;
          state_d  = IDLE;
        end
      end
    endcase
    // A memory wait freezes the EX unit; a flush overrides everything.
    if (mem_stall) begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done_raw = 1'b0;
    end
    if (flush_req) begin
      state_d  = IDLE;
      cnt_d    = '0;
      done_raw = 1'b0;
    end
  end

  always_comb begin
    stall_raw = 6'b000000;
    if (flush_req)        stall_raw = 6'b000000;
    else if (mem_stall)   stall_raw = 6'b011111;
    else if (ex_stall)    stall_raw = 6'b001111;
    else if (stallreq_id) stall_raw = 6'b000111;
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_raw[0] && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Outputs are held low for the whole reset pulse, not just after the edge.
  assign stall        = rst ? 6'b000000 : stall_raw;
  assign flush        = flush_req & ~rst;
  assign ex_mc_en     = ~rst & ~mem_stall & (ex_mc_req | (state_q == EX_BUSY));
  assign ex_mc_done   = done_raw & ~rst;
  assign busy         = (state_q == EX_BUSY) & ~rst;
  assign stall_cycles = stall_cycles_q;

endmodule
